// File: rtl/bus_mux_arb.sv
// Registered bus multiplexer with direct-select, fixed-priority and round-robin arbitration.
// Optional even-parity output bus_par is enabled by defining BUS_MUX_PARITY_EN.
module bus_mux_arb #(
  parameter  int NUM_SRC = 24,
  parameter  int DATA_W  = 32,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_vld,
  input  logic                      bus_ready,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic [SEL_W-1:0]          grant_idx,
  output logic                      sel_err
`ifdef BUS_MUX_PARITY_EN
  ,
  output logic                      bus_par
`endif
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PRIO   = 2'b01,
    MODE_RR     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [DATA_W-1:0]    bus_data_q, bus_data_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]     grant_idx_q, grant_idx_d;
  logic                 sel_err_q, sel_err_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 bus_par_q, bus_par_d;

  logic                 cand_vld;
  logic [SEL_W-1:0]     cand_idx;
  logic [DATA_W-1:0]    cand_data;
  logic [NUM_SRC-1:0]   cand_onehot;
  logic                 illegal;
  logic [2*NUM_SRC-1:0] req_rot;
  logic                 slot;
  logic                 load;
  int                   rr_sum;
  int                   rr_inc;

  assign slot    = !bus_valid_q || bus_ready;
  assign load    = slot && cand_vld;
  // Rotating the doubled request vector puts rr_ptr at bit 0, so the wrap search is a plain lowest-bit scan.
  assign req_rot = {src_req, src_req} >> rr_ptr_q;

  // NOTE: every combinational output gets a default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    illegal  = 1'b0;
    rr_sum   = 0;
    case (mode_sel)
      MODE_DIRECT: begin
        if (sel_vld) begin
          if (int'(sel) < NUM_SRC) begin
            cand_vld = 1'b1;
            cand_idx = sel;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      MODE_PRIO: begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (src_req[i]) begin
            cand_vld = 1'b1;
            cand_idx = SEL_W'(i);
          end
        end
      end
      MODE_RR: begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (req_rot[i]) begin
            cand_vld = 1'b1;
            rr_sum   = int'(rr_ptr_q) + i;
          end
        end
        if (rr_sum >= NUM_SRC) rr_sum = rr_sum - NUM_SRC;
        cand_idx = SEL_W'(rr_sum);
      end
      default: illegal = |src_req;
    endcase
  end

  always_comb begin
    cand_data   = '0;
    cand_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand_idx == SEL_W'(i)) begin
        cand_data      = src_data[i*DATA_W +: DATA_W];
        cand_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    bus_data_d  = bus_data_q;
    bus_valid_d = bus_valid_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    bus_par_d   = bus_par_q;
    sel_err_d   = slot && illegal;
    rr_inc      = int'(cand_idx) + 1;
    if (slot) bus_valid_d = cand_vld;
    if (load) begin
      bus_data_d  = cand_data;
      grant_d     = cand_onehot;
      grant_idx_d = cand_idx;
      bus_par_d   = ^cand_data;
      if (mode_sel == MODE_RR) rr_ptr_d = (rr_inc >= NUM_SRC) ? '0 : SEL_W'(rr_inc);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
      bus_par_q   <= 1'b0;
    end else begin
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
      bus_par_q   <= bus_par_d;
    end
  end

  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign sel_err   = sel_err_q;

`ifdef BUS_MUX_PARITY_EN
  assign bus_par = bus_par_q;
`else
  logic unused_par;
  assign unused_par = bus_par_q;
`endif

endmodule

// File: tb/tb_bus_mux_arb.sv
// Scoreboard bench for bus_mux_arb: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_bus_mux_arb;

  localparam int NUM_SRC = 24;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = $clog2(NUM_SRC);

  logic                      clk = 1'b0;
  logic                      clr_n;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_req;
  logic [1:0]                mode;
  logic [SEL_W-1:0]          sel;
  logic                      sel_vld;
  logic                      bus_ready;
  logic [DATA_W-1:0]         bus_data;
  logic                      bus_valid;
  logic [NUM_SRC-1:0]        grant;
  logic [SEL_W-1:0]          grant_idx;
  logic                      sel_err;
`ifdef BUS_MUX_PARITY_EN
  logic                      bus_par;
`endif

  bus_mux_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .src_data  (src_data),
    .src_req   (src_req),
    .mode      (mode),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .sel_err   (sel_err)
`ifdef BUS_MUX_PARITY_EN
    ,
    .bus_par   (bus_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SEL_W-1:0]   idx;
    logic [NUM_SRC-1:0] grant;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_word(input int idx, input logic [DATA_W-1:0] data);
    exp_t e;
    e.data  = data;
    e.idx   = SEL_W'(idx);
    e.grant = NUM_SRC'(1) << idx;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mode      = 2'b00;
    sel       = '0;
    sel_vld   = 1'b0;
    src_req   = '0;
    bus_ready = 1'b0;
    clr_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  // A word leaves the bus at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (clr_n && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {32'h0, bus_data}, 64'hDEAD_0000);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_bus_data", 64'(bus_data), 64'(mon_e.data));
        check("mon_grant_idx", 64'(grant_idx), 64'(mon_e.idx));
        check("mon_grant", 64'(grant), 64'(mon_e.grant));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + i;
    mode = 2'b00; sel = '0; sel_vld = 1'b0; src_req = '0; bus_ready = 1'b0;
    clr_n = 1'b0;
    #12;
    check("rst_bus_data", 64'(bus_data), 64'h0);
    check("rst_bus_valid", 64'(bus_valid), 64'h0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_grant_idx", 64'(grant_idx), 64'h0);
    check("rst_sel_err", 64'(sel_err), 64'h0);
`ifdef BUS_MUX_PARITY_EN
    check("rst_bus_par", 64'(bus_par), 64'h0);
`endif
    @(posedge clk); #1 clr_n = 1'b1;

    // Direct select, immediately followed by an out-of-range select.
    mode = 2'b00; sel = 5'd5; sel_vld = 1'b1; bus_ready = 1'b1;
    expect_word(5, 32'h1000_0005);
    tick();
    check("m00_valid", 64'(bus_valid), 64'h1);
    check("m00_grant_direct", 64'(grant), 64'h20);
    sel = 5'd30;
    tick();
    check("selerr_pulse", 64'(sel_err), 64'h1);
    check("selerr_valid_clr", 64'(bus_valid), 64'h0);
    check("selerr_data_hold", 64'(bus_data), 64'h1000_0005);
    check("selerr_idx_hold", 64'(grant_idx), 64'd5);
    sel_vld = 1'b0;
    tick();
    check("selerr_one_cycle", 64'(sel_err), 64'h0);

    // Fixed priority with backpressure while requests change.
    mode = 2'b01; src_req = 24'h000A40; bus_ready = 1'b0; sel = 5'd2; sel_vld = 1'b1;
    expect_word(6, 32'h1000_0006);
    tick();
    src_req = 24'h000001;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_data_hold", 64'(bus_data), 64'h1000_0006);
      check("bp_idx_hold", 64'(grant_idx), 64'd6);
      check("bp_valid_hold", 64'(bus_valid), 64'h1);
    end
    bus_ready = 1'b1;
    expect_word(0, 32'h1000_0000);
    tick();
    check("m01_after_bp_idx", 64'(grant_idx), 64'd0);
    src_req = '0; sel_vld = 1'b0;
    tick();
    check("m01_drained_valid", 64'(bus_valid), 64'h0);

    // Reserved mode with a request raised.
    mode = 2'b11; src_req = 24'h000001;
    tick();
    check("m11_sel_err", 64'(sel_err), 64'h1);
    check("m11_no_load", 64'(bus_valid), 64'h0);
    src_req = '0;
    tick();
    check("m11_pulse_end", 64'(sel_err), 64'h0);

    // Round robin from a fresh pointer, covering the wrap from 23 back to 0.
    do_reset();
    mode = 2'b10; src_req = 24'h800021; bus_ready = 1'b1;
    expect_word(0, 32'h1000_0000);
    expect_word(5, 32'h1000_0005);
    expect_word(23, 32'h1000_0017);
    expect_word(0, 32'h1000_0000);
    expect_word(5, 32'h1000_0005);
    repeat (5) tick();
    src_req = '0;
    tick();
    tick();

    // Reset in the middle of a held word, then the pointer must restart at 0.
    mode = 2'b10; src_req = 24'h000100; bus_ready = 1'b0;
    tick();
    check("mid_valid_before", 64'(bus_valid), 64'h1);
    src_req = '0;
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus_valid), 64'h0);
    check("mid_rst_data", 64'(bus_data), 64'h0);
    check("mid_rst_grant", 64'(grant), 64'h0);
    check("mid_rst_idx", 64'(grant_idx), 64'h0);
    @(posedge clk); #1 clr_n = 1'b1;
    src_req = 24'hFFFFFF; bus_ready = 1'b1;
    expect_word(0, 32'h1000_0000);
    tick();
    src_req = '0;
    tick();
    tick();

`ifdef BUS_MUX_PARITY_EN
    src_data[0 +: DATA_W]      = 32'h0000_0007;
    src_data[DATA_W +: DATA_W] = 32'h0000_0003;
    mode = 2'b00; sel = 5'd0; sel_vld = 1'b1; bus_ready = 1'b1;
    expect_word(0, 32'h0000_0007);
    tick();
    check("par_odd_src", 64'(bus_par), 64'h1);
    sel = 5'd1;
    expect_word(1, 32'h0000_0003);
    tick();
    check("par_even_src", 64'(bus_par), 64'h0);
    sel_vld = 1'b0;
    tick();
`endif

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_mux_arb.md
Name: bus_mux_arb

Overview:
Parametrised, registered bus multiplexer with arbitration. It selects one of NUM_SRC DATA_W-bit sources onto the shared datapath bus. Selection uses one of three modes: explicit select, fixed priority or round robin. The output is a single register stage with a valid/ready handshake. It replaces the fixed 24-input combinational bus mux in the CPU datapath and makes unmapped select codes and arbitration visible to the control unit.

Parameters:
NUM_SRC, 24, number of source ports; legal range 2..64
DATA_W, 32, width of each source and of the bus
SEL_W, $clog2(NUM_SRC), width of sel and grant_idx; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous active-low reset
src_data  input  NUM_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W]
src_req  input  NUM_SRC  per-source request; used in modes 01 and 10
mode  input  2  00 direct select, 01 fixed priority, 10 round robin, 11 reserved
sel  input  SEL_W  source index in mode 00
sel_vld  input  1  sel is valid this cycle in mode 00
bus_ready  input  1  downstream accepts bus_data
bus_data  output  DATA_W  registered bus value
bus_valid  output  1  bus_data holds an unconsumed word
grant  output  NUM_SRC  one-hot index of the source that produced bus_data
grant_idx  output  SEL_W  binary index of the same source
sel_err  output  1  one-cycle pulse on an illegal select request

Behaviour:
- Reset, asynchronous on clr_n low:
  - bus_data=0, bus_valid=0, grant=0, grant_idx=0, sel_err=0.
  - Internal round-robin pointer rr_ptr=0.
- Load slot: slot = !bus_valid || bus_ready. A load happens only when slot is open and a candidate exists.
- Latency: a candidate presented in cycle N appears on bus_data/bus_valid in cycle N+1.
- Candidate by mode:
  - 00: candidate exists when sel_vld=1 and sel<NUM_SRC; source = sel.
  - 01: lowest-index set bit of src_req.
  - 10: first set bit of src_req, searching from rr_ptr upward with wrap at NUM_SRC-1 to 0.
  - 11: never a candidate.
- On load:
  - bus_data <= selected source; bus_valid <= 1.
  - grant <= one-hot of the source; grant_idx <= its index.
  - In mode 10 only: rr_ptr <= index+1, wrapping to 0 past NUM_SRC-1.
- Slot open, no candidate:
  - bus_valid <= 0.
  - bus_data, grant and grant_idx hold their last values; they are not cleared.
- Backpressure: while bus_valid=1 and bus_ready=0, all outputs and rr_ptr hold. Source changes are ignored.
- sel_err is asserted for exactly one cycle, in the cycle after the cause:
  - mode 00, sel_vld=1, sel>=NUM_SRC, slot open; or
  - mode=11 with any src_req bit set, slot open.
  - The illegal cycle causes no load. It does clear bus_valid if the slot was open.
- Simultaneous events:
  - Back-to-back loads with bus_ready=1 give full throughput, one word per cycle.
  - A mode change takes effect on the next load decision.
  - rr_ptr persists across mode changes and changes only on mode-10 loads.
- Modes 01 and 10 ignore sel and sel_vld. Mode 00 ignores src_req.
- Reset asserted mid-transfer discards the held word immediately. No partial state survives.

Optional Feature:
BUS_MUX_PARITY_EN:
- When defined: adds output bus_par (1 bit), the even parity of the selected source.
  - Registered together with bus_data under identical load, hold and backpressure rules.
  - Reset value 0.
- When undefined: the bus_par port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, NUM_SRC=24, DATA_W=32: clr_n low mid-cycle with bus_valid=1 -> all outputs 0 immediately; after release, rr_ptr=0 (first mode-10 grant with src_req=all ones is index 0).
- Mode 00, src i = 0x1000_0000+i, sel=5, sel_vld=1, bus_ready=1 -> next cycle bus_data=0x1000_0005, bus_valid=1, grant_idx=5, grant=0x000020.
- Mode 00, sel=30, sel_vld=1 -> sel_err=1 for one cycle; bus_valid=0; bus_data holds the previous value.
- Mode 01, src_req=0x000A40 -> grant_idx=6. Hold bus_ready=0 for 3 cycles while src_req changes to 0x000001 -> bus_data and grant_idx unchanged until bus_ready=1; then grant_idx=0 on the following load.
- Mode 10, src_req=0x800021, bus_ready=1 continuously -> grant_idx sequence 0,5,23,0,5 (wrap verified).
- With BUS_MUX_PARITY_EN, select source value 0x0000_0007 -> bus_par=1; value 0x0000_0003 -> bus_par=0.
